// File: rtl/fp32_divider.sv
// fp32_divider: sequential IEEE-754 single-precision divider.
// Restoring division, one quotient bit per cycle, valid/ready on both sides.
// Special operands (Inf/NaN exponent, zero/denormal divisor, zero/denormal
// dividend) bypass the iteration and complete one edge after acceptance.
// Optional build macro: FP32_DIV_EARLY_TERM_EN -- stop iterating as soon as
// the partial remainder reaches zero (results are bit-identical).
//
// state    | meaning
// ---------+-------------------------------------------------------------
// S_IDLE   | in_ready high; waiting for in_valid
// S_DIVIDE | one restoring-division step per cycle, counter 25 -> 0
// S_ROUND  | normalise, round to nearest even, overflow/underflow check
// S_DONE   | out_valid high; result/flags held until out_ready

module fp32_divider #(
    parameter int EXP_BIAS  = 127,
    parameter int QUOT_BITS = 26
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a_operand,
    input  logic [31:0] b_operand,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic        Exception,
    output logic        DivByZero,
    output logic        Overflow,
    output logic        Underflow
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DIVIDE = 2'd1,
        S_ROUND  = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    localparam logic signed [9:0] BIAS_M1    = 10'(EXP_BIAS - 1);
    localparam logic [4:0]        COUNT_LOAD = 5'(QUOT_BITS - 1);

    state_t             r_state;
    logic               r_sign;
    logic signed [9:0]  r_exp;
    logic [23:0]        r_mb;
    logic [25:0]        r_rem;
    logic [25:0]        r_quot;
    logic [4:0]         r_count;

    // operand decode for the accept cycle
    logic [7:0]         w_ea;
    logic [7:0]         w_eb;
    logic               w_sign_in;
    logic signed [9:0]  w_exp_in;

    assign w_ea      = a_operand[30:23];
    assign w_eb      = b_operand[30:23];
    assign w_sign_in = a_operand[31] ^ b_operand[31];
    assign w_exp_in  = $signed({2'b00, w_ea}) - $signed({2'b00, w_eb}) + BIAS_M1;

    // one restoring step: remainder is always below 2*mb, so 26 bits suffice
    logic [26:0]        w_trial;
    logic               w_ge;
    logic [25:0]        w_rem_sel;
    logic [25:0]        w_rem_next;
    logic [25:0]        w_quot_next;

    assign w_trial     = {1'b0, r_rem} - {3'b000, r_mb};
    assign w_ge        = ~w_trial[26];
    assign w_rem_sel   = w_ge ? w_trial[25:0] : r_rem;
    assign w_rem_next  = w_rem_sel << 1;
    assign w_quot_next = {r_quot[24:0], w_ge};

    // normalisation and rounding of the finished quotient
    logic               w_norm;
    logic [22:0]        w_mant;
    logic               w_guard;
    logic               w_sticky;
    logic               w_round_up;
    logic [23:0]        w_mant_inc;
    logic signed [9:0]  w_exp_rnd;

    assign w_norm     = r_quot[25];
    assign w_mant     = w_norm ? r_quot[24:2] : r_quot[23:1];
    assign w_guard    = w_norm ? r_quot[1] : r_quot[0];
    assign w_sticky   = (w_norm & r_quot[0]) | (|r_rem);
    assign w_round_up = w_guard & (w_sticky | w_mant[0]);
    assign w_mant_inc = {1'b0, w_mant} + {23'd0, w_round_up};
    assign w_exp_rnd  = r_exp + $signed({9'd0, w_norm}) + $signed({9'd0, w_mant_inc[23]});

    assign in_ready = (r_state == S_IDLE);

    // main controller: accept, iterate, round, hand off
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state   <= S_IDLE;
            r_sign    <= 1'b0;
            r_exp     <= '0;
            r_mb      <= '0;
            r_rem     <= '0;
            r_quot    <= '0;
            r_count   <= '0;
            out_valid <= 1'b0;
            result    <= '0;
            Exception <= 1'b0;
            DivByZero <= 1'b0;
            Overflow  <= 1'b0;
            Underflow <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_sign    <= w_sign_in;
                        r_exp     <= w_exp_in;
                        r_mb      <= {1'b1, b_operand[22:0]};
                        Exception <= 1'b0;
                        DivByZero <= 1'b0;
                        Overflow  <= 1'b0;
                        Underflow <= 1'b0;
                        if (w_ea == 8'hFF || w_eb == 8'hFF) begin
                            result    <= '0;
                            Exception <= 1'b1;
                            out_valid <= 1'b1;
                            r_state   <= S_DONE;
                        end else if (w_eb == 8'h00) begin
                            result    <= {w_sign_in, 8'hFF, 23'd0};
                            DivByZero <= 1'b1;
                            out_valid <= 1'b1;
                            r_state   <= S_DONE;
                        end else if (w_ea == 8'h00) begin
                            result    <= {w_sign_in, 31'd0};
                            out_valid <= 1'b1;
                            r_state   <= S_DONE;
                        end else begin
                            r_quot  <= '0;
                            r_rem   <= {2'b00, 1'b1, a_operand[22:0]};
                            r_count <= COUNT_LOAD;
                            r_state <= S_DIVIDE;
                        end
                    end
                end
                S_DIVIDE: begin
                    r_rem   <= w_rem_next;
                    r_quot  <= w_quot_next;
                    r_count <= r_count - 5'd1;
`ifdef FP32_DIV_EARLY_TERM_EN
                    // remaining quotient bits are all zero once the remainder is
                    if (w_rem_next == '0) begin
                        r_quot  <= w_quot_next << r_count;
                        r_state <= S_ROUND;
                    end else if (r_count == 5'd0) begin
                        r_state <= S_ROUND;
                    end
`else
                    if (r_count == 5'd0) begin
                        r_state <= S_ROUND;
                    end
`endif
                end
                S_ROUND: begin
                    if (w_exp_rnd >= 10'sd255) begin
                        result   <= {r_sign, 8'hFF, 23'd0};
                        Overflow <= 1'b1;
                    end else if (w_exp_rnd <= 10'sd0) begin
                        result    <= {r_sign, 31'd0};
                        Underflow <= 1'b1;
                    end else begin
                        result <= {r_sign, w_exp_rnd[7:0], w_mant_inc[22:0]};
                    end
                    out_valid <= 1'b1;
                    r_state   <= S_DONE;
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        r_state   <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fp32_divider.sv
// Testbench for fp32_divider: directed corner cases plus randomized operands,
// checked through an expected-response queue drained by an output monitor.

module tb_fp32_divider;

    logic        CLK = 1'b0;
    logic        RESET_N = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] a_operand = '0;
    logic [31:0] b_operand = '0;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] result;
    logic        Exception;
    logic        DivByZero;
    logic        Overflow;
    logic        Underflow;

    int errors = 0;
    int checks = 0;
    logic [35:0] exp_q[$];

    fp32_divider dut (
        .CLK       (CLK),
        .RESET_N   (RESET_N),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a_operand (a_operand),
        .b_operand (b_operand),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .Exception (Exception),
        .DivByZero (DivByZero),
        .Overflow  (Overflow),
        .Underflow (Underflow)
    );

    always #5 CLK = ~CLK;

    // reference: exact integer quotient/remainder, then IEEE-style rounding
    // returns {result, Exception, DivByZero, Overflow, Underflow}
    function automatic logic [35:0] ref_div(input logic [31:0] a, input logic [31:0] b);
        logic   s;
        int     ea, eb, e;
        longint ma, mb, num, q, r, m, g, st;
        s  = a[31] ^ b[31];
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        if (ea == 255 || eb == 255) return {32'd0, 4'b1000};
        if (eb == 0) return {s, 8'hFF, 23'd0, 4'b0100};
        if (ea == 0) return {s, 31'd0, 4'b0000};
        ma  = 64'(8388608 + int'(a[22:0]));
        mb  = 64'(8388608 + int'(b[22:0]));
        num = ma * 33554432;
        q   = num / mb;
        r   = num % mb;
        e   = ea - eb + 126;
        if (q >= 33554432) begin
            e  = e + 1;
            m  = (q / 4) % 8388608;
            g  = (q / 2) % 2;
            st = ((q % 2) != 0 || r != 0) ? 1 : 0;
        end else begin
            m  = (q / 2) % 8388608;
            g  = q % 2;
            st = (r != 0) ? 1 : 0;
        end
        if (g == 1 && (st == 1 || (m % 2) == 1)) m = m + 1;
        if (m == 8388608) begin
            m = 0;
            e = e + 1;
        end
        if (e >= 255) return {s, 8'hFF, 23'd0, 4'b0010};
        if (e <= 0) return {s, 31'd0, 4'b0001};
        return {s, 8'(e), 23'(m), 4'b0000};
    endfunction

    function automatic logic [31:0] rand_fp();
        logic [7:0] e;
        int sel;
        sel = int'($urandom_range(0, 11));
        case (sel)
            0:       e = 8'h00;
            1:       e = 8'hFF;
            2, 3:    e = 8'($urandom_range(1, 254));
            default: e = 8'($urandom_range(100, 154));
        endcase
        rand_fp = {1'($urandom), e, 23'($urandom)};
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got=%h want=%h", name, got, want);
        end
    endtask

    // monitor: a handshake happens on the next rising edge whenever both are high
    always @(negedge CLK) begin
        logic [35:0] got;
        logic [35:0] want;
        if (RESET_N && out_valid && out_ready) begin
            got = {result, Exception, DivByZero, Overflow, Underflow};
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_output: got=%h want=none", got);
            end else begin
                want = exp_q.pop_front();
                if (got !== want) begin
                    errors++;
                    $display("FAIL result_flags: got=%h want=%h (res,exc,dbz,ovf,unf)", got, want);
                end
            end
        end
    end

    // issue one operation (called just after a rising edge), wait for the result,
    // hold off out_ready for 'delay' cycles, then take it
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input int delay, output int lat);
        check("in_ready_before_issue", 64'(in_ready), 64'd1);
        a_operand = a;
        b_operand = b;
        in_valid  = 1'b1;
        exp_q.push_back(ref_div(a, b));
        @(posedge CLK);
        #1;
        in_valid  = 1'b0;
        a_operand = $urandom;
        b_operand = $urandom;
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(posedge CLK);
            #1;
            lat++;
        end
        if (!out_valid) begin
            checks++;
            errors++;
            $display("FAIL out_valid_timeout: got=none want=valid within 100 edges");
        end
        repeat (delay) begin
            @(posedge CLK);
            #1;
        end
        out_ready = 1'b1;
        @(posedge CLK);
        #1;
        out_ready = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL global_timeout: got=stuck want=finish");
        $fatal(1, "timeout");
    end

    initial begin
        int lat;
        int n;
        repeat (3) @(posedge CLK);
        #1;
        check("reset_outputs", {31'd0, in_ready, out_valid, result, Exception, DivByZero, Overflow, Underflow},
              {31'd0, 1'b1, 1'b0, 32'd0, 4'b0000});
        RESET_N = 1'b1;
        @(posedge CLK);
        #1;

        run_op(32'h40C00000, 32'h40000000, 0, lat);
`ifdef FP32_DIV_EARLY_TERM_EN
        check("latency_6_div_2_max", 64'(lat <= 28), 64'd1);
`else
        check("latency_6_div_2", 64'(lat), 64'd28);
`endif
        check("idle_after_take", {62'd0, in_ready, out_valid}, {62'd0, 1'b1, 1'b0});

        run_op(32'h3F800000, 32'hC0400000, 1, lat);
        run_op(32'h3F800000, 32'h00000000, 0, lat);
        check("latency_div_by_zero", 64'(lat), 64'd1);
        run_op(32'h7F800000, 32'h3F800000, 2, lat);
        check("latency_exception", 64'(lat), 64'd1);
        run_op(32'h7F000000, 32'h00800000, 0, lat);
        run_op(32'h00800000, 32'h7F000000, 0, lat);
        run_op(32'h00000000, 32'hBF800000, 0, lat);
        check("latency_zero_dividend", 64'(lat), 64'd1);

        // backpressure: result held, second request ignored
        a_operand = 32'h40C00000;
        b_operand = 32'h40000000;
        in_valid  = 1'b1;
        exp_q.push_back(ref_div(32'h40C00000, 32'h40000000));
        @(posedge CLK);
        #1;
        a_operand = 32'h3F800000;
        b_operand = 32'h00000000;
        n = 1;
        while (!out_valid && n < 100) begin
            @(posedge CLK);
            #1;
            n++;
        end
        for (int i = 0; i < 10; i++) begin
            check("backpressure_hold", {30'd0, out_valid, in_ready, result}, {30'd0, 1'b1, 1'b0, 32'h40400000});
            @(posedge CLK);
            #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge CLK);
        #1;
        check("backpressure_release", {62'd0, in_ready, out_valid}, {62'd0, 1'b1, 1'b0});
        repeat (30) @(posedge CLK);
        #1;
        out_ready = 1'b0;
        check("no_spurious_result", 64'(out_valid), 64'd0);

        // reset in the middle of an iteration
        a_operand = 32'h40C00000;
        b_operand = 32'h40000000;
        in_valid  = 1'b1;
        @(posedge CLK);
        #1;
        in_valid = 1'b0;
        repeat (10) @(posedge CLK);
        #2;
        RESET_N = 1'b0;
        #1;
        check("reset_mid_divide", {62'd0, in_ready, out_valid}, {62'd0, 1'b1, 1'b0});
        @(posedge CLK);
        #3;
        RESET_N = 1'b1;
        @(posedge CLK);
        #1;
        run_op(32'h40C00000, 32'h40000000, 0, lat);
`ifndef FP32_DIV_EARLY_TERM_EN
        check("latency_after_reset", 64'(lat), 64'd28);
`endif

        for (int i = 0; i < 40; i++) begin
            run_op(rand_fp(), rand_fp(), int'($urandom_range(0, 3)), lat);
        end

        repeat (3) @(posedge CLK);
        #1;
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fp32_divider.md
Name: fp32_divider

Overview:
- Sequential IEEE-754 single-precision divider; the inverse operation of the FPU's combinational multiplier, sharing its flag set and special-case result encodings.
- Iterative restoring division, one quotient bit per cycle, behind a valid/ready handshake.
- Sits in the CPU FPU beside the multiplier; the FPU control stalls on in_ready/out_valid.

Parameters:
- EXP_BIAS, 127, exponent bias used in exponent arithmetic.
- QUOT_BITS, 26, quotient bits generated: 24 mantissa bits, 1 normalisation bit, 1 guard bit. Only 26 is supported.

Ports:
- CLK  input  1  clock, rising edge.
- RESET_N  input  1  asynchronous, active-low reset.
- in_valid  input  1  operands presented.
- in_ready  output  1  divider idle; accepts operands.
- a_operand  input  32  dividend.
- b_operand  input  32  divisor.
- out_valid  output  1  result and flags valid.
- out_ready  input  1  consumer takes result.
- result  output  32  quotient.
- Exception  output  1  either operand exponent is 255.
- DivByZero  output  1  divisor is zero or denormal.
- Overflow  output  1  result exponent is ≥255.
- Underflow  output  1  result exponent is ≤0.

Behaviour:
- Reset, asynchronous, any state: state=IDLE; in_ready=1 (combinational on IDLE); out_valid=0; result=0; all flags 0; internal registers cleared. A reset mid-division discards the operation and emits no output.
- FSM states: IDLE, DIVIDE, ROUND, DONE.
- IDLE: in_ready=1. Operands are accepted on a clock edge with in_valid=1.
  - Capture sign = a[31]^b[31].
  - Capture mantissas: ma={1,a[22:0]}, mb={1,b[22:0]}.
  - Capture exponent as a 10-bit signed value: ea-eb+EXP_BIAS-1.
  - Classify special cases in priority order:
    - Exception (ea==255 or eb==255): result=0.
    - DivByZero (eb==0; denormal divisor treated as zero): result={sign,8'hFF,23'd0}.
    - Zero dividend (ea==0; denormal dividend flushed): result={sign,31'd0}.
  - On a special case: latch the result and flag, go to DONE. Otherwise clear the 26-bit quotient, set the remainder to ma (26 bits), go to DIVIDE.
- DIVIDE: 26 iterations, counter 25→0.
  - Each iteration computes trial = rem - mb.
  - If trial ≥ 0: rem = trial<<1, shift in quotient bit 1.
  - Otherwise: rem = rem<<1, shift in quotient bit 0.
  - After the last iteration, go to ROUND.
- ROUND (one cycle):
  - norm = q[25].
    - If norm=1: mantissa=q[24:2], guard=q[1], sticky=q[0] | (rem!=0).
    - If norm=0: mantissa=q[23:1], guard=q[0], sticky=(rem!=0).
  - Exponent adds norm.
  - Round to nearest even: add guard & (sticky | mantissa[0]). A carry out of the mantissa zeroes the mantissa and increments the exponent.
  - Then check exponent ≥255 → Overflow, result={sign,8'hFF,23'd0}. Else check exponent ≤0 → Underflow, result={sign,31'd0}. Else result={sign,exp[7:0],mantissa}.
  - Go to DONE.
- DONE: out_valid=1; result and flags held stable. The edge with out_ready=1 clears out_valid and returns to IDLE. A new operand can be accepted no earlier than the cycle after.
- Latency, counting from the accept edge:
  - Normal operands: out_valid=1 after 28 edges (1 load, 26 DIVIDE, 1 ROUND).
  - Special cases: out_valid=1 after 1 edge.
- Only one operation is in flight at a time. in_valid is ignored outside IDLE. Operand inputs are not required to stay stable after acceptance.

Optional Feature:
- Macro: FP32_DIV_EARLY_TERM_EN.
- Defined: in DIVIDE, once rem==0 after an iteration, the remaining iterations are skipped. The quotient is left-shifted by the remaining count in a single cycle and the FSM goes to ROUND. Latency drops to (iterations until rem==0)+2; results are bit-identical.
- Not defined: always 26 DIVIDE cycles; fixed latency of 28.

Test Plan:
- 0x40C00000 / 0x40000000 (6.0/2.0) -> result 0x40400000, no flags; out_valid exactly 28 edges after accept (macro off).
- 0x3F800000 / 0xC0400000 (1.0/-3.0) -> 0xBEAAAAAB; checks round-to-nearest-even and sign.
- 0x3F800000 / 0x00000000 -> 0x7F800000, DivByZero=1, out_valid after 1 edge; 0x7F800000 / 0x3F800000 -> 0x00000000, Exception=1.
- 0x7F000000 / 0x00800000 -> 0x7F800000, Overflow=1; 0x00800000 / 0x7F000000 -> 0x00000000, Underflow=1.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid -> result stable, in_ready=0, a second in_valid is ignored; the out_ready pulse returns the block to IDLE.
- Assert RESET_N=0 at DIVIDE iteration 10 -> out_valid=0, in_ready=1 immediately. A following 6.0/2.0 completes correctly.
